// File: rtl/cond_exec_ctrl_pkg.sv
// Shared constants for the conditional-execution controller: cond encodings, NZCV bit positions, flush FSM states.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/cond_exec_ctrl_if.sv
// ID/WB/IF-side signals of the conditional-execution controller.
// master = pipeline side driving decode/writeback, slave = the controller.
interface cond_exec_ctrl_if;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_set_flags;
    logic       id_is_branch;
    logic       freeze;
    logic       wb_flags_we;
    logic [3:0] wb_flags;
    logic       id_stall;
    logic       id_exec;
    logic       id_kill;
    logic       flush_if;
    logic [3:0] sr_flags;
    logic       sb_err;

    modport master (
        output id_valid, id_cond, id_set_flags, id_is_branch, freeze, wb_flags_we, wb_flags,
        input  id_stall, id_exec, id_kill, flush_if, sr_flags, sb_err
    );

    modport slave (
        input  id_valid, id_cond, id_set_flags, id_is_branch, freeze, wb_flags_we, wb_flags,
        output id_stall, id_exec, id_kill, flush_if, sr_flags, sb_err
    );
endinterface

// File: rtl/cond_exec_ctrl_eval.sv
// Condition-code evaluator: (cond, NZCV) -> pass.
// Purely combinational, zero latency, no backpressure.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_exec_ctrl.sv
// ID-stage conditional-execution control: NZCV register, in-flight flag scoreboard, stall/issue, branch flush.
// Issue decision is same-cycle (WB flags bypassed); stalls ID while older flag writers are outstanding or the scoreboard is full.
module cond_exec_ctrl
    import cond_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int FLUSH_CYCLES = 1
) (
    input logic             CLK,
    input logic             RST,
    cond_exec_ctrl_if.slave bus
);
    localparam int PW = $clog2(MAX_INFLIGHT + 1);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES);

    logic [3:0]    sr_q;
    logic [3:0]    eff_flags;
    logic [PW-1:0] pending;
    logic [PW-1:0] pend_net;
    logic [CW-1:0] cnt;
    state_t        state;
    logic          err_q;
    logic          pass, stall, issue, exec, kill, sb_inc, sb_dec;

    assign eff_flags = bus.wb_flags_we ? bus.wb_flags : sr_q;

    cond_eval u_eval (
        .cond  (bus.id_cond),
        .flags (eff_flags),
        .pass  (pass)
    );

    // A writeback this cycle retires one pending writer, so it no longer counts as a hazard.
    assign pend_net = pending - PW'(bus.wb_flags_we);
    assign stall = bus.id_valid & ~bus.freeze &
                   (((bus.id_cond != COND_AL) & (pend_net != '0)) |
                    (bus.id_set_flags & (pending == PEND_MAX) & ~bus.wb_flags_we));
    assign issue  = bus.id_valid & ~bus.freeze & ~stall;
    assign exec   = issue & pass & (state == IDLE);
    assign kill   = issue & (~pass | (state == FLUSH));
    assign sb_inc = exec & bus.id_set_flags;
    assign sb_dec = bus.wb_flags_we;

    assign bus.id_stall = stall & ~RST;
    assign bus.id_exec  = exec & ~RST;
    assign bus.id_kill  = kill & ~RST;
    assign bus.flush_if = exec & bus.id_is_branch & ~RST;
    assign bus.sr_flags = RST ? 4'h0 : sr_q;
    assign bus.sb_err   = err_q & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q    <= 4'h0;
            pending <= '0;
            err_q   <= 1'b0;
        end else begin
            if (bus.wb_flags_we)
                sr_q <= bus.wb_flags;
            if (sb_inc & ~sb_dec) begin
                if (pending == PEND_MAX)
                    err_q <= 1'b1;
                else
                    pending <= pending + PW'(1);
            end else if (sb_dec & ~sb_inc) begin
                if (pending == '0)
                    err_q <= 1'b1;
                else
                    pending <= pending - PW'(1);
            end
        end
    end

    // Flush window counts valid ID slots, so a frozen pipeline stretches it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exec & bus.id_is_branch) begin
                        state <= FLUSH;
                        cnt   <= CNT_INIT;
                    end
                end
                FLUSH: begin
                    if (~bus.freeze & bus.id_valid) begin
                        if (cnt == CW'(1))
                            state <= IDLE;
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
